// File: rtl/io_pkg.sv
// ============================================================================
//  Package    : io_pkg
//  Description: Register map and STATUS bit positions for uart_mmio_ctrl.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;

  // Byte offsets inside the 256-byte register window
  localparam logic [7:0] IO_STATUS  = 8'h00;
  localparam logic [7:0] IO_RXDATA  = 8'h04;
  localparam logic [7:0] IO_TXDATA  = 8'h08;
  localparam logic [7:0] IO_LEVEL   = 8'h0C;
  localparam logic [7:0] IO_CYCLES  = 8'h10;
  localparam logic [7:0] IO_INSTRET = 8'h14;
  localparam logic [7:0] IO_CTR_CLR = 8'h18;

  // Only address bits [4:2] take part in register selection
  localparam logic [2:0] SEL_STATUS  = IO_STATUS[4:2];
  localparam logic [2:0] SEL_RXDATA  = IO_RXDATA[4:2];
  localparam logic [2:0] SEL_TXDATA  = IO_TXDATA[4:2];
  localparam logic [2:0] SEL_LEVEL   = IO_LEVEL[4:2];
  localparam logic [2:0] SEL_CYCLES  = IO_CYCLES[4:2];
  localparam logic [2:0] SEL_INSTRET = IO_INSTRET[4:2];
  localparam logic [2:0] SEL_CTR_CLR = IO_CTR_CLR[4:2];

  // STATUS register bit positions
  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_RX_OVF       = 2;

endpackage

`default_nettype wire

// File: rtl/io_fifo.sv
// ============================================================================
//  Module     : io_fifo
//  Description: Synchronous show-ahead FIFO. The head entry is presented on
//               dout_o whenever the FIFO is non-empty (0 when empty). A push
//               into a full FIFO succeeds only when a pop happens in the same
//               cycle; a pop from an empty FIFO is ignored.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);
  // Gating with empty keeps stale storage from leaking out after reset
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
// ============================================================================
//  Module     : uart_mmio_ctrl
//  Description: MMIO bridge between the CPU load/store path and the UART.
//               TX/RX FIFOs, sticky RX-overflow flag, registered load data.
//               Optional build macro MMIO_COUNTERS_EN adds the CYCLES and
//               INSTRET counters and the CTR_CLR register.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_mmio_ctrl
  import io_pkg::*;
#(
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic        io_re,
  output logic [31:0] io_rdata,
  input  logic        inst_retired,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  logic                        addr_hit;
  logic [2:0]                  sel;
  logic                        rd_hit;
  logic                        wr_hit;
  logic                        tx_push;
  logic                        tx_full;
  logic                        tx_empty;
  logic [$clog2(TX_DEPTH):0]   tx_count;
  logic                        rx_pop;
  logic                        rx_full;
  logic                        rx_empty;
  logic [7:0]                  rx_head;
  logic [$clog2(RX_DEPTH):0]   rx_count;
  logic                        ovf_set;
  logic                        ovf_clr;
  logic                        ovf_q;
  logic [31:0]                 rdata_d;
  logic [31:0]                 io_rdata_q;
  logic [31:0]                 cycles_val;
  logic [31:0]                 instret_val;
  logic                        unused_bits;

  assign addr_hit = (io_addr[31:8] == BASE_ADDR[31:8]);
  assign sel      = io_addr[4:2];
  assign rd_hit   = io_re && addr_hit;
  assign wr_hit   = io_we && addr_hit;

  assign tx_push  = wr_hit && (sel == SEL_TXDATA);
  assign rx_pop   = rd_hit && (sel == SEL_RXDATA);
  // A byte landing on a full RX FIFO is lost unless the CPU frees a slot now
  assign ovf_set  = uart_rx_valid && rx_full && !(rx_pop && !rx_empty);
  assign ovf_clr  = wr_hit && (sel == SEL_STATUS) && io_wdata[ST_RX_OVF];

  assign uart_tx_valid = !tx_empty;
  assign uart_rx_ready = !rst;
  assign io_rdata      = io_rdata_q;

  assign unused_bits = ^{io_addr[7:5], io_addr[1:0], io_wdata[31:8]};

  io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (io_wdata[7:0]),
    .pop_i   (uart_tx_ready),
    .dout_o  (uart_tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (uart_rx_valid),
    .din_i   (uart_rx_data),
    .pop_i   (rx_pop),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

`ifdef MMIO_COUNTERS_EN
  logic        ctr_clr;
  logic [31:0] cycles_q;
  logic [31:0] instret_q;

  assign ctr_clr     = wr_hit && (sel == SEL_CTR_CLR);
  assign cycles_val  = cycles_q;
  assign instret_val = instret_q;

  // Free-running counters; a clear discards that cycle's increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else if (ctr_clr) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      cycles_q  <= cycles_q + 32'd1;
      instret_q <= instret_q + 32'(inst_retired);
    end
  end
`else
  logic unused_inst_retired;

  assign cycles_val          = '0;
  assign instret_val         = '0;
  assign unused_inst_retired = inst_retired;
`endif

  // Load data selection from the current (pre-edge) register state
  always_comb begin
    rdata_d = '0;
    case (sel)
      SEL_STATUS: begin
        rdata_d[ST_TX_NOT_FULL]  = !tx_full;
        rdata_d[ST_RX_NOT_EMPTY] = !rx_empty;
        rdata_d[ST_RX_OVF]       = ovf_q;
      end
      SEL_RXDATA:  rdata_d = {24'd0, rx_head};
      SEL_LEVEL:   rdata_d = {7'd0, 9'(rx_count), 7'd0, 9'(tx_count)};
      SEL_CYCLES:  rdata_d = cycles_val;
      SEL_INSTRET: rdata_d = instret_val;
      default:     rdata_d = '0;
    endcase
  end

  // Registered load data and sticky overflow (set has priority over clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_rdata_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (rd_hit) io_rdata_q <= rdata_d;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire
